s3g_packet_rx: RTL

Parametrised S3G packet receiver sitting between `uart_transceiver` (byte stream `rx_data`/`rx_done`) and the command decoder. It frames packets (start byte, length, payload, CRC-8), stores the payload in an internal buffer of `MAX_LEN` bytes, and validates the CRC. It holds a validated packet until the consumer acknowledges it, and reports framing errors with a cause code. It adds length-limit checking, an explicit consumer handshake, overrun detection and an optional inter-byte timeout.

---
 rtl/s3g_pkg.sv | 32 +++
 rtl/s3g_pkt_buf.sv | 58 +++++
 rtl/s3g_packet_rx.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/s3g_pkg.sv
// Shared types for the S3G packet receiver: FSM states, error causes, CRC-8/MAXIM step.
// Combinational helpers only. No flow control here.
// Used by s3g_packet_rx and s3g_pkt_buf.
package s3g_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LEN  = 2'd1,
    S_DATA = 2'd2,
    S_CRC  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_CRC     = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_OVERRUN = 2'd3
  } err_t;

  localparam logic [7:0] CRC8_POLY_REFL = 8'h8C;

  // One byte of CRC-8/MAXIM, LSB-first (reflected 0x31).
  function automatic logic [7:0] nextCRC8_D8(input logic [7:0] data, input logic [7:0] crc);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC8_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/s3g_pkt_buf.sv
// Dual-bank payload RAM: one bank is staged by the receiver while the other holds the committed packet.
// Read data registered, 1 cycle from i_rd_addr; commit swaps banks on the next edge.
// No backpressure: writes and commits are accepted every cycle.
module s3g_pkt_buf
  import s3g_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [7:0]        i_wr_data,
  input  logic              i_commit,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [7:0]        o_rd_data
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(MAX_LEN);

  logic [7:0] r_mem0 [MAX_LEN];
  logic [7:0] r_mem1 [MAX_LEN];
  logic       r_held;
  logic [7:0] r_rd_data;
  logic [7:0] w_rd_word;
  logic       w_rd_in_range;

  assign w_rd_in_range = ({1'b0, i_rd_addr} < DEPTH);

  always_comb begin
    w_rd_word = 8'h00;
    if (w_rd_in_range) begin
      w_rd_word = r_held ? r_mem1[i_rd_addr] : r_mem0[i_rd_addr];
    end
  end

  // Writes always target the bank that is not currently held.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      if (r_held) r_mem0[i_wr_addr] <= i_wr_data;
      else        r_mem1[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_held    <= 1'b0;
      r_rd_data <= 8'h00;
    end else begin
      r_rd_data <= w_rd_word;
      if (i_commit) r_held <= ~r_held;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/s3g_packet_rx.sv
// S3G packet receiver: frames D5/len/payload/CRC-8, holds a validated packet until buffer_ack.
// packet_done/packet_error one cycle after the deciding rx_done; buffer_data 1 cycle after buffer_addr.
// No backpressure on rx_done: a START while a packet is held is dropped as OVERRUN. Option: S3G_RX_TIMEOUT_EN.
module s3g_packet_rx
  import s3g_pkg::*;
#(
  parameter logic [7:0] START_BYTE     = 8'hD5,
  parameter int         MAX_LEN        = 32,
  parameter int         TIMEOUT_CYCLES = 65535,
  localparam int        ADDR_W         = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  input  logic [ADDR_W-1:0] buffer_addr,
  output logic [7:0]        buffer_data,
  output logic [7:0]        payload_len,
  output logic              buffer_valid,
  input  logic              buffer_ack,
  output logic              packet_done,
  output logic              packet_error,
  output logic [1:0]        error_code
);

  localparam logic [7:0] LEN_MAX = 8'(MAX_LEN);

  state_t              r_state;
  logic   [7:0]        r_len;
  logic   [7:0]        r_cnt;
  logic   [7:0]        r_crc;
  logic                r_valid;
  logic   [7:0]        r_plen;
  logic                r_done;
  logic                r_err;
  err_t                r_code;

  logic                w_wr_en;
  logic   [ADDR_W-1:0] w_wr_addr;
  logic                w_commit;
  logic                w_timeout;

  assign w_wr_en   = (r_state == S_DATA) && rx_done;
  assign w_wr_addr = r_cnt[ADDR_W-1:0];
  assign w_commit  = (r_state == S_CRC) && rx_done && (rx_data == r_crc);

`ifdef S3G_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_to_cnt;

  // Counts idle cycles inside a packet; the TIMEOUT_CYCLES-th idle cycle fires.
  assign w_timeout = (r_state != S_IDLE) && !rx_done && (r_to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if ((r_state == S_IDLE) || rx_done || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_len   <= 8'h00;
      r_cnt   <= 8'h00;
      r_crc   <= 8'h00;
      r_valid <= 1'b0;
      r_plen  <= 8'h00;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= ERR_CRC;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (buffer_ack && r_valid) r_valid <= 1'b0;

      if (w_timeout) begin
        r_err   <= 1'b1;
        r_code  <= ERR_TIMEOUT;
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            // Overrun is judged on the registered valid, so a same-cycle ack does not rescue it.
            if (rx_done && (rx_data == START_BYTE)) begin
              if (r_valid) begin
                r_err  <= 1'b1;
                r_code <= ERR_OVERRUN;
              end else begin
                r_state <= S_LEN;
              end
            end
          end
          S_LEN: begin
            if (rx_done) begin
              if (rx_data > LEN_MAX) begin
                r_err   <= 1'b1;
                r_code  <= ERR_LEN;
                r_state <= S_IDLE;
              end else begin
                r_len   <= rx_data;
                r_cnt   <= 8'h00;
                r_crc   <= 8'h00;
                r_state <= (rx_data == 8'h00) ? S_CRC : S_DATA;
              end
            end
          end
          S_DATA: begin
            if (rx_done) begin
              r_cnt <= r_cnt + 8'd1;
              r_crc <= nextCRC8_D8(rx_data, r_crc);
              if ((r_cnt + 8'd1) == r_len) r_state <= S_CRC;
            end
          end
          S_CRC: begin
            if (rx_done) begin
              if (rx_data == r_crc) begin
                r_valid <= 1'b1;
                r_plen  <= r_len;
                r_done  <= 1'b1;
              end else begin
                r_err  <= 1'b1;
                r_code <= ERR_CRC;
              end
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  s3g_pkt_buf #(
    .MAX_LEN (MAX_LEN),
    .ADDR_W  (ADDR_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (rx_data),
    .i_commit  (w_commit),
    .i_rd_addr (buffer_addr),
    .o_rd_data (buffer_data)
  );

  assign buffer_valid = r_valid;
  assign payload_len  = r_plen;
  assign packet_done  = r_done;
  assign packet_error = r_err;
  assign error_code   = r_code;

endmodule
